// File: rtl/e_mdu_ctrl_if.sv
// E-stage to MDU issue-controller bundle: request handshake, D-stage stall
// query and the MDU start/select pins, grouped so one port carries them all.
interface e_mdu_ctrl_if;
    logic       req_valid;
    logic [2:0] req_op;
    logic       req_ready;
    logic       d_md_use;
    logic       mdu_start;
    logic [2:0] mdu_select;
    logic       busy;
    logic       done;
    logic       stall;

    // Pipeline side: presents operations and the D-stage HI/LO use flag.
    modport master (
        output req_valid,
        output req_op,
        output d_md_use,
        input  req_ready,
        input  mdu_start,
        input  mdu_select,
        input  busy,
        input  done,
        input  stall
    );

    // Controller side.
    modport slave (
        input  req_valid,
        input  req_op,
        input  d_md_use,
        output req_ready,
        output mdu_start,
        output mdu_select,
        output busy,
        output done,
        output stall
    );
endinterface

// File: rtl/e_mdu_ctrl.sv
// Issue controller for the E-stage multiply/divide unit. Holds one pending
// operation, issues one-cycle start pulses with a registered select, counts
// each operation's latency and raises stall for HI/LO-dependent D-stage ops.
module e_mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned MT_CYCLES   = 1
) (
    input  logic         clk,
    input  logic         reset,
    e_mdu_ctrl_if.slave  bus
);

    localparam int unsigned MAX_A = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned MAX_L = (MAX_A > MT_CYCLES) ? MAX_A : MT_CYCLES;
    localparam int unsigned CNT_W = ($clog2(MAX_L + 1) > 4) ? $clog2(MAX_L + 1) : 4;

    localparam logic [2:0] SEL_IDLE = 3'b111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Opcodes 110/111 are swallowed: accepted but never issued.
    function automatic logic op_is_valid(input logic [2:0] op);
        return (op != 3'b110) && (op != 3'b111);
    endfunction

    function automatic logic [CNT_W-1:0] op_latency(input logic [2:0] op);
        logic [CNT_W-1:0] lat;
        case (op)
            3'b000, 3'b001: lat = CNT_W'(MULT_CYCLES);
            3'b010, 3'b011: lat = CNT_W'(DIV_CYCLES);
            3'b100, 3'b101: lat = CNT_W'(MT_CYCLES);
            default:        lat = {CNT_W{1'b0}};
        endcase
        return lat;
    endfunction

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_valid_q;
    logic [2:0]       pend_op_q;
    logic             mdu_start_q;
    logic [2:0]       mdu_select_q;

    logic             done_s;
    logic             free_s;
    logic             accept_s;
    logic             issue_d;
    logic [2:0]       issue_op_d;
    logic             store_s;

    // Issue arbitration: a pending op always wins over a fresh request.
    always_comb begin
        done_s     = (state_q == RUN) && (cnt_q == CNT_W'(1));
        free_s     = (state_q == IDLE) || done_s;
        accept_s   = bus.req_valid && !pend_valid_q;
        issue_d    = 1'b0;
        issue_op_d = SEL_IDLE;
        store_s    = 1'b0;
        if (free_s && pend_valid_q) begin
            issue_d    = 1'b1;
            issue_op_d = pend_op_q;
        end else if (free_s && accept_s && op_is_valid(bus.req_op)) begin
            issue_d    = 1'b1;
            issue_op_d = bus.req_op;
        end else if (!free_s && accept_s && op_is_valid(bus.req_op)) begin
            store_s = 1'b1;
        end else begin
            issue_d = 1'b0;
        end
    end

    // Controller FSM: issue, latency countdown and the single pending slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            pend_valid_q <= 1'b0;
            pend_op_q    <= 3'b000;
            mdu_start_q  <= 1'b0;
            mdu_select_q <= SEL_IDLE;
        end else begin
            if (issue_d) begin
                mdu_start_q  <= 1'b1;
                mdu_select_q <= issue_op_d;
                state_q      <= RUN;
                cnt_q        <= op_latency(issue_op_d);
            end else begin
                // Select must return to 111: the MDU writes HI/LO on 100/101
                // even without a start pulse.
                mdu_start_q  <= 1'b0;
                mdu_select_q <= SEL_IDLE;
                if (free_s) begin
                    state_q <= IDLE;
                    cnt_q   <= {CNT_W{1'b0}};
                end else begin
                    cnt_q   <= cnt_q - CNT_W'(1);
                end
            end

            if (free_s && pend_valid_q) begin
                pend_valid_q <= 1'b0;
            end else if (store_s) begin
                pend_valid_q <= 1'b1;
                pend_op_q    <= bus.req_op;
            end else begin
                pend_valid_q <= pend_valid_q;
            end
        end
    end

    assign bus.req_ready  = !pend_valid_q;
    assign bus.mdu_start  = mdu_start_q;
    assign bus.mdu_select = mdu_select_q;
    assign bus.done       = done_s;
    assign bus.busy       = (state_q == RUN) || pend_valid_q;
    // req_valid covers an op accepted this cycle that has not started yet.
    assign bus.stall      = bus.d_md_use && ((state_q == RUN) || pend_valid_q || bus.req_valid);

endmodule
